stack_ctrl: RTL and testbench
=============================

# stack_ctrl

LIFO controller that owns the 1024×4 single-port `stack_ram` block RAM and turns it into a hardware stack with push/pop handshakes, occupancy tracking and error flags. It sits directly upstream of the RAM: it generates the RAM's address, enable, write-enable and write data, and it registers pop results from the RAM's read port back to the drawing/fill engine in the IT8951 pixel pipeline.

## Interface
- `ADDR_W`, 10: RAM address width. Stack depth is `DEPTH = 2**ADDR_W` = 1024.
- `DATA_W`, 4: stack word width. Matches the RAM `dia`/`doa` width.
- `clk`  in  1: single clock, also drives the RAM `clka`.
- `rst`  in  1: reset, asynchronous, active-high.
- `clear`  in  1: synchronous flush; empties the stack and clears the error flags.
- `push`  in  1: push request, single-cycle qualified.
- `push_data`  in  DATA_W: word to push.
- `pop`  in  1: pop request, single-cycle qualified.
- `pop_valid`  out  1: `pop_data` is valid this cycle.
- `pop_data`  out  DATA_W: popped word.
- `count`  out  ADDR_W+1: current occupancy, 0..1024.
- `empty`  out  1: asserted when `count == 0`.
- `full`  out  1: asserted when `count == DEPTH`.
- `ovf`  out  1: sticky flag, set by a push while full.
- `unf`  out  1: sticky flag, set by a pop while empty.
- `ram_addra`  out  ADDR_W: to RAM `addra`.
- `ram_cea`  out  1: to RAM `cea`.
- `ram_wea`  out  1: to RAM `wea`.
- `ram_dia`  out  DATA_W: to RAM `dia`.
- `ram_doa`  in  DATA_W: from RAM `doa`. Read is synchronous, with no output register; data is valid the cycle after the address edge.

## Operation
- Stack pointer `sp` (ADDR_W+1 bits) equals `count`. `sp` points at the next free slot; the top of stack is at `sp-1`.
- The RAM drive signals are combinational from `push`, `pop`, `clear` and `sp`. The RAM samples them on the same edge that updates `sp`.
- Accepted push (`push` and not full): `ram_addra = sp[ADDR_W-1:0]`, `ram_cea = 1`, `ram_wea = 1`, `ram_dia = push_data`, then `sp += 1`.
- Accepted pop (`pop`, not full-push, and not empty): `ram_addra = sp-1`, `ram_cea = 1`, `ram_wea = 0`, then `sp -= 1`, and the registered `pop_pend` is set to 1.
- Idle cycle: `ram_cea = 0` and `ram_wea = 0`. `ram_addra` and `ram_dia` hold don't-care values.
- Priority, highest first: `clear` > `push` > `pop`.
  - When `push` and `pop` arrive together, the push is performed and the pop is dropped without setting `unf`.
  - The caller must serialise push and pop.
- Push while full: no RAM access, `sp` unchanged, `ovf` ← 1.
- Pop while empty: no RAM access, no `pop_valid`, `unf` ← 1.
- `clear`: `sp` ← 0, `ovf` and `unf` ← 0, `pop_pend` ← 0, and RAM enables are forced to 0. RAM contents are not erased.
- Wrap-around: `sp` never wraps. At `DEPTH`, `ram_addra` uses only the low bits, but no write is issued there.

## Timing
- Reset values:
  - `count = 0`, `empty = 1`, `full = 0`, `ovf = 0`, `unf = 0`.
  - `pop_valid = 0`, `pop_data = 0`.
  - `ram_cea = 0` and `ram_wea = 0` while `rst` is high.
- Pop latency is 1 cycle:
  - Request in cycle N.
  - RAM reads at edge N.
  - `pop_valid = 1` and `pop_data = ram_doa` in cycle N+1 (combinational pass-through gated by `pop_pend`).
- Throughput is 1 operation per cycle. Back-to-back pops return consecutive words on consecutive cycles.
- A pop in the cycle after a push returns the just-written word, because the RAM write completed at the previous edge.
- `count`, `empty`, `full`, `ovf` and `unf` update at the edge that accepts the operation and are visible in cycle N+1.
- Reset asserted mid-pop discards the pending `pop_valid` asynchronously.

## Configuration
- Macro `STACK_HWM_EN` defined:
  - Adds output `hwm` (ADDR_W+1), the high-water mark.
  - `hwm` updates to `max(hwm, count_next)` on every accepted push.
  - `hwm` is reset to 0 by `rst` and by `clear`.
- Macro not defined: the `hwm` port and its register are absent, and all other behaviour is identical.

## Test plan
- Reset, then push 0x1, 0x2, 0x3 on consecutive cycles, then pop 3 times back-to-back -> `pop_valid` for 3 cycles, returning data 0x3, 0x2, 0x1; `count` goes 3 -> 0; `empty` = 1.
- Push 1024 words (value = index mod 16), then one more push with data 0xF -> `full` = 1, `count` = 1024, `ovf` = 1, no RAM write; the first pop returns 0xF (index 1023 mod 16).
- Pop while empty -> `unf` = 1, `pop_valid` stays 0, `ram_cea` = 0; a later `clear` drops `unf` to 0.
- Push 0xA and pop asserted in the same cycle with `count` = 2 -> `count` = 3, no `pop_valid`, `unf` = 0.
- Push 0x5, then pop, then assert `rst` in the `pop_valid` cycle -> `pop_valid` drops immediately and `count` = 0 after reset.
- With `STACK_HWM_EN`: push 7, pop 4, push 2 -> `hwm` = 7; after `clear`, `hwm` = 0.

Source files
------------

// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO controller that drives a 1024x4 single-port synchronous-read stack RAM.
// Defining STACK_HWM_EN adds the high-water-mark output hwm.
module stack_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf,
`ifdef STACK_HWM_EN
  output logic [ADDR_W:0]   hwm,
`endif
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_cea,
  output logic              ram_wea,
  output logic [DATA_W-1:0] ram_dia,
  input  logic [DATA_W-1:0] ram_doa
);

  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] SP_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] sp;
  logic [ADDR_W:0] sp_inc;
  logic [ADDR_W:0] sp_dec;
  logic            is_full;
  logic            is_empty;
  logic            push_ok;
  logic            pop_ok;
  logic            push_rej;
  logic            pop_rej;
  logic            pop_pend;

  assign sp_inc   = sp + SP_ONE;
  assign sp_dec   = sp - SP_ONE;
  assign is_full  = (sp == DEPTH);
  assign is_empty = (sp == '0);

  // Push outranks pop, so a simultaneous pop is silently dropped.
  assign push_ok  = push && !clear && !is_full;
  assign push_rej = push && !clear && is_full;
  assign pop_ok   = pop && !push && !clear && !is_empty;
  assign pop_rej  = pop && !push && !clear && is_empty;

  always_comb begin
    ram_cea   = 1'b0;
    ram_wea   = 1'b0;
    ram_dia   = push_data;
    ram_addra = push ? sp[ADDR_W-1:0] : sp_dec[ADDR_W-1:0];
    if (!rst) begin
      ram_cea = push_ok || pop_ok;
      ram_wea = push_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      pop_pend <= 1'b0;
    end else if (clear) begin
      sp       <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      pop_pend <= 1'b0;
    end else begin
      pop_pend <= pop_ok;
      if (push_ok) begin
        sp <= sp_inc;
      end else if (pop_ok) begin
        sp <= sp_dec;
      end
      if (push_rej) begin
        ovf <= 1'b1;
      end
      if (pop_rej) begin
        unf <= 1'b1;
      end
    end
  end

`ifdef STACK_HWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm <= '0;
    end else if (clear) begin
      hwm <= '0;
    end else if (push_ok && (sp_inc > hwm)) begin
      hwm <= sp_inc;
    end
  end
`endif

  // The RAM read port has no output register, so the result is passed straight through.
  assign pop_valid = pop_pend;
  assign pop_data  = pop_pend ? ram_doa : '0;
  assign count     = sp;
  assign empty     = is_empty;
  assign full      = is_full;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed and random stimulus for stack_ctrl against a queue-based stack model.
// Includes a behavioural model of the synchronous-read stack RAM.
module tb_stack_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [3:0]  push_data = 4'h0;
  logic        pop_valid;
  logic [3:0]  pop_data;
  logic [10:0] count;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        unf;
`ifdef STACK_HWM_EN
  logic [10:0] hwm;
`endif
  logic [9:0]  ram_addra;
  logic        ram_cea;
  logic        ram_wea;
  logic [3:0]  ram_dia;
  logic [3:0]  ram_doa = 4'h0;
  logic [3:0]  mem [DEPTH];

  int total = 0;
  int bad = 0;

  logic [3:0] model_q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  bit         m_pend = 1'b0;
  logic [3:0] m_data = 4'h0;
  int         m_hwm = 0;

  stack_ctrl #(.ADDR_W(10), .DATA_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf),
`ifdef STACK_HWM_EN
    .hwm       (hwm),
`endif
    .ram_addra (ram_addra),
    .ram_cea   (ram_cea),
    .ram_wea   (ram_wea),
    .ram_dia   (ram_dia),
    .ram_doa   (ram_doa)
  );

  always #5 clk = ~clk;

  // Stack RAM: synchronous read, no output register.
  always @(posedge clk) begin
    if (ram_cea) begin
      if (ram_wea) mem[ram_addra] <= ram_dia;
      else         ram_doa <= mem[ram_addra];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int n;
    n = model_q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unf", 32'(unf), 32'(m_unf));
    chk("pop_valid", 32'(pop_valid), 32'(m_pend));
    if (m_pend) chk("pop_data", 32'(pop_data), 32'(m_data));
`ifdef STACK_HWM_EN
    chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result one cycle later.
  task automatic applyStimulus(input bit c, input bit p, input bit q, input logic [3:0] d);
    int  n;
    bit  do_push;
    bit  do_pop;
    clear = c;
    push = p;
    pop = q;
    push_data = d;
    n = model_q.size();
    do_push = p && !c && (n < DEPTH);
    do_pop = q && !p && !c && (n > 0);
    #1;
    chk("ram_cea", 32'(ram_cea), 32'(do_push || do_pop));
    chk("ram_wea", 32'(ram_wea), 32'(do_push));
    if (do_push) begin
      chk("push_addr", 32'(ram_addra), 32'(n % DEPTH));
      chk("push_dia", 32'(ram_dia), 32'(d));
    end
    if (do_pop) chk("pop_addr", 32'(ram_addra), 32'(n - 1));
    if (c) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_pend = 1'b0;
      m_hwm = 0;
    end else if (p) begin
      m_pend = 1'b0;
      if (n == DEPTH) m_ovf = 1'b1;
      else begin
        model_q.push_back(d);
        if (n + 1 > m_hwm) m_hwm = n + 1;
      end
    end else if (q) begin
      if (n == 0) begin
        m_unf = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_data = model_q.pop_back();
        m_pend = 1'b1;
      end
    end else begin
      m_pend = 1'b0;
    end
    @(negedge clk);
    clear = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    checkOutput();
  endtask

  task automatic modelReset();
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_pend = 1'b0;
    m_hwm = 0;
  endtask

  initial begin
    bit c;
    bit p;
    bit q;
    int r;

    // Reset with requests pending: RAM must stay disabled.
    push = 1'b1;
    pop = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cea", 32'(ram_cea), 32'd0);
    chk("rst_wea", 32'(ram_wea), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    push = 1'b0;
    pop = 1'b0;
    rst = 1'b0;
    modelReset();
    checkOutput();

    // Three pushes then three back-to-back pops.
    applyStimulus(0, 1, 0, 4'h1);
    applyStimulus(0, 1, 0, 4'h2);
    applyStimulus(0, 1, 0, 4'h3);
    applyStimulus(0, 0, 1, 4'h0);
    chk("lifo_0", 32'(pop_data), 32'h3);
    applyStimulus(0, 0, 1, 4'h0);
    chk("lifo_1", 32'(pop_data), 32'h2);
    applyStimulus(0, 0, 1, 4'h0);
    chk("lifo_2", 32'(pop_data), 32'h1);
    chk("lifo_empty", 32'(empty), 32'd1);

    // Fill to capacity, then overflow.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 4'(i));
    applyStimulus(0, 1, 0, 4'hF);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd1024);
    chk("full_ovf", 32'(ovf), 32'd1);
    applyStimulus(0, 0, 1, 4'h0);
    chk("full_first_pop", 32'(pop_data), 32'hF);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 0, 1, 4'h0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Underflow and clear.
    applyStimulus(0, 0, 1, 4'h0);
    chk("unf_set", 32'(unf), 32'd1);
    chk("unf_no_valid", 32'(pop_valid), 32'd0);
    applyStimulus(1, 0, 0, 4'h0);
    chk("unf_cleared", 32'(unf), 32'd0);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Simultaneous push and pop: push wins.
    applyStimulus(0, 1, 0, 4'h6);
    applyStimulus(0, 1, 0, 4'h7);
    applyStimulus(0, 1, 1, 4'hA);
    chk("pp_count", 32'(count), 32'd3);
    chk("pp_no_valid", 32'(pop_valid), 32'd0);
    chk("pp_unf", 32'(unf), 32'd0);
    applyStimulus(0, 0, 1, 4'h0);
    chk("pp_top", 32'(pop_data), 32'hA);

`ifdef STACK_HWM_EN
    applyStimulus(1, 0, 0, 4'h0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 4'(i));
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 4'h0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 4'(i));
    chk("hwm_peak", 32'(hwm), 32'd7);
    applyStimulus(1, 0, 0, 4'h0);
    chk("hwm_clear", 32'(hwm), 32'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      c = (r < 2);
      p = (r >= 2) && (r < 56);
      q = (r >= 46);
      applyStimulus(c, p, q, 4'($urandom));
    end

    // Reset during the pop_valid cycle.
    applyStimulus(1, 0, 0, 4'h0);
    applyStimulus(0, 1, 0, 4'h5);
    applyStimulus(0, 0, 1, 4'h0);
    chk("rp_valid_before", 32'(pop_valid), 32'd1);
    chk("rp_data_before", 32'(pop_data), 32'h5);
    rst = 1'b1;
    #1;
    chk("rp_valid_dropped", 32'(pop_valid), 32'd0);
    chk("rp_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
